// File: rtl/dcache_replace_queue_pkg.sv
// Shared types and constants for the DCache victim writeback queue.
package dcache_pkg;

  localparam int REPLACE_SIZE = 4;
  localparam int LINE_WORDS   = 8;
  localparam int XLEN         = 32;
  localparam int BLK_W        = 27;
  localparam int MISS_W       = 2;
  localparam int AXI_ID       = 1;

  localparam int PTR_W  = $clog2(REPLACE_SIZE);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS * XLEN / 8);
  localparam int ADDR_W = BLK_W + OFF_W;
  localparam int LINE_W = LINE_WORDS * XLEN;
  localparam int STRB_W = XLEN / 8;
  localparam int ID_W   = 1;

  localparam logic [1:0]      BURST_INCR   = 2'b01;
  localparam logic [ID_W-1:0] DCACHE_WB_ID = ID_W'(AXI_ID);

  typedef struct packed {
    logic [BLK_W-1:0]  addr;
    logic [MISS_W-1:0] missIdx;
    logic [LINE_W-1:0] data;
  } ReplaceEntry;

  typedef enum logic [1:0] {
    RQ_IDLE,
    RQ_AW,
    RQ_W,
    RQ_B
  } rq_state_e;

  // Select one beat of a victim line; word 0 sits in the LSBs.
  function automatic logic [XLEN-1:0] line_word(input logic [LINE_W-1:0] line,
                                                input logic [BEAT_W-1:0] idx);
    return line[idx*XLEN +: XLEN];
  endfunction

endpackage

// File: rtl/dcache_replace_queue_cam.sv
// Address-conflict lookup: does any pending victim (or the one arriving now) hold chk_addr?
module rq_addr_cam
  import dcache_pkg::*;
(
  input  logic                               en,
  input  logic [BLK_W-1:0]                   addr,
  input  logic [BLK_W-1:0]                   chk_addr,
  input  logic [REPLACE_SIZE-1:0]            valid,
  input  logic [REPLACE_SIZE-1:0][BLK_W-1:0] entry_addr,
  output logic                               conflict
);

  logic [REPLACE_SIZE-1:0] hit;

  generate
    for (genvar gi = 0; gi < REPLACE_SIZE; gi++) begin : g_cmp
      assign hit[gi] = valid[gi] && (entry_addr[gi] == chk_addr);
    end
  endgenerate

  // The same-cycle enqueue is bypassed so a fetch cannot slip past a victim being captured.
  assign conflict = (|hit) || (en && (addr == chk_addr));

endmodule

// File: rtl/dcache_replace_queue.sv
// Victim writeback buffer: captures evicted dirty lines and drains them as AXI write bursts.
module dcache_replace_queue
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BLK_W-1:0]    addr,
  input  logic [LINE_W-1:0]   data,
  input  logic [MISS_W-1:0]   missIdx,
  output logic                full,
  output logic                wend,
  output logic [MISS_W-1:0]   missIdx_o,
  input  logic [BLK_W-1:0]    chk_addr,
  output logic                chk_conflict,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [7:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic [ID_W-1:0]     aw_id,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [XLEN-1:0]     w_data,
  output logic [STRB_W-1:0]   w_strb,
  output logic                w_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  rq_state_e                          state_reg;
  logic [PTR_W-1:0]                   head_reg, tail_reg;
  logic [CNT_W-1:0]                   count_reg, count_next;
  logic [REPLACE_SIZE-1:0]            valid_reg;
  logic [BEAT_W-1:0]                  beat_reg;
  logic                               full_reg, wend_reg;
  logic [MISS_W-1:0]                  missidx_reg;
  logic                               aw_valid_reg, w_valid_reg, w_last_reg;
  logic [ADDR_W-1:0]                  aw_addr_reg;
  logic [XLEN-1:0]                    w_data_reg;
  ReplaceEntry                        entry_mem [REPLACE_SIZE];
  ReplaceEntry                        head_entry;
  logic [REPLACE_SIZE-1:0][BLK_W-1:0] entry_addr;
  logic                               enq, deq;
  logic                               unused_b_resp;

  // Error responses have no recovery path, so b_resp is deliberately dropped.
  assign unused_b_resp = ^b_resp;

  assign enq        = en && !full_reg;
  assign deq        = (state_reg == RQ_B) && b_valid;
  assign head_entry = entry_mem[head_reg];

  generate
    for (genvar gi = 0; gi < REPLACE_SIZE; gi++) begin : g_addr
      assign entry_addr[gi] = entry_mem[gi].addr;
    end
  endgenerate

  // Occupancy after this cycle's enqueue and dequeue; both together leave it unchanged.
  always_comb begin
    count_next = count_reg;
    if (enq && !deq) begin
      count_next = count_reg + 1'b1;
    end else if (deq && !enq) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Victim payload storage; no reset needed because valid_reg qualifies every entry.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_mem[tail_reg] <= '{addr: addr, missIdx: missIdx, data: data};
    end
  end

  // Pointers, occupancy, full flag and the capture acknowledge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      valid_reg   <= '0;
      full_reg    <= 1'b0;
      wend_reg    <= 1'b0;
      missidx_reg <= '0;
    end else begin
      wend_reg <= enq;
      if (enq) begin
        missidx_reg         <= missIdx;
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end
      // While not full, head and tail never coincide with a live entry, so these never collide.
      if (deq) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(REPLACE_SIZE));
    end
  end

  // Writeback FSM: one serialised AW -> W burst -> B sequence per head entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= RQ_IDLE;
      beat_reg     <= '0;
      aw_valid_reg <= 1'b0;
      aw_addr_reg  <= '0;
      w_valid_reg  <= 1'b0;
      w_data_reg   <= '0;
      w_last_reg   <= 1'b0;
    end else begin
      case (state_reg)
        RQ_IDLE: begin
          if (valid_reg[head_reg]) begin
            state_reg    <= RQ_AW;
            aw_valid_reg <= 1'b1;
            aw_addr_reg  <= {head_entry.addr, {OFF_W{1'b0}}};
          end
        end
        RQ_AW: begin
          if (aw_ready) begin
            state_reg    <= RQ_W;
            aw_valid_reg <= 1'b0;
            beat_reg     <= '0;
            w_valid_reg  <= 1'b1;
            w_data_reg   <= line_word(head_entry.data, '0);
            w_last_reg   <= (LINE_WORDS == 1);
          end
        end
        RQ_W: begin
          if (w_ready) begin
            if (beat_reg == LAST_BEAT) begin
              state_reg   <= RQ_B;
              w_valid_reg <= 1'b0;
              w_last_reg  <= 1'b0;
            end else begin
              beat_reg   <= beat_reg + 1'b1;
              w_data_reg <= line_word(head_entry.data, beat_reg + 1'b1);
              w_last_reg <= ((beat_reg + 1'b1) == LAST_BEAT);
            end
          end
        end
        RQ_B: begin
          if (b_valid) begin
            state_reg <= RQ_IDLE;
          end
        end
        default: state_reg <= RQ_IDLE;
      endcase
    end
  end

  rq_addr_cam u_cam (
    .en         (en),
    .addr       (addr),
    .chk_addr   (chk_addr),
    .valid      (valid_reg),
    .entry_addr (entry_addr),
    .conflict   (chk_conflict)
  );

  assign full      = full_reg;
  assign wend      = wend_reg;
  assign missIdx_o = missidx_reg;
  assign aw_valid  = aw_valid_reg;
  assign aw_addr   = aw_addr_reg;
  assign aw_len    = 8'(LINE_WORDS - 1);
  assign aw_size   = 3'($clog2(XLEN / 8));
  assign aw_burst  = BURST_INCR;
  assign aw_id     = DCACHE_WB_ID;
  assign w_valid   = w_valid_reg;
  assign w_data    = w_data_reg;
  assign w_strb    = {STRB_W{1'b1}};
  assign w_last    = w_last_reg;
  assign b_ready   = 1'b1;

endmodule

// File: tb/tb_dcache_replace_queue.sv
// Scoreboard bench for the victim writeback queue: stimulus pushes expectations, a monitor pops them.
module tb_dcache_replace_queue;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [26:0]  addr, chk_addr;
  logic [255:0] data;
  logic [1:0]   missIdx, missIdx_o;
  logic         full, wend, chk_conflict;
  logic         aw_valid, aw_ready;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size;
  logic [1:0]   aw_burst;
  logic [0:0]   aw_id;
  logic         w_valid, w_ready, w_last;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;

  logic w_rdy_man, w_toggle, w_tog;
  logic b_man, b_auto, auto_b;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_wend[$];
  logic [31:0] exp_aw[$];
  logic [32:0] exp_w[$];   // {last, data}

  assign w_ready = w_toggle ? w_tog : w_rdy_man;
  assign b_valid = b_man | b_auto;
  assign b_resp  = 2'b00;

  always #5 clk = ~clk;

  dcache_replace_queue dut (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .data(data), .missIdx(missIdx),
    .full(full), .wend(wend), .missIdx_o(missIdx_o), .chk_addr(chk_addr),
    .chk_conflict(chk_conflict), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_id(aw_id), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last), .b_valid(b_valid), .b_ready(b_ready),
    .b_resp(b_resp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Monitor: compares whatever the DUT presents against the head of each expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (wend) begin
        if (exp_wend.size() == 0) fail_now("wend_unexpected", $sformatf("got missIdx_o=%0d, expected no wend", missIdx_o));
        else begin
          check("wend_missidx", missIdx_o, exp_wend.pop_front());
          $display("wend  missIdx_o=%0d", missIdx_o);
        end
      end
      if (aw_valid) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected", $sformatf("got aw_addr=0x%0h, expected no AW", aw_addr));
        else begin
          check("aw_addr", aw_addr, exp_aw[0]);
          if (aw_ready) begin
            check("aw_len", aw_len, 8'd7);
            check("aw_size", aw_size, 3'd2);
            check("aw_burst", aw_burst, 2'b01);
            check("aw_id", aw_id, 1'b1);
            $display("aw    addr=0x%08h", aw_addr);
            void'(exp_aw.pop_front());
          end
        end
      end
      if (w_valid) begin
        if (exp_w.size() == 0) fail_now("w_unexpected", $sformatf("got w_data=0x%0h, expected no beat", w_data));
        else begin
          check("w_beat", {w_last, w_data}, exp_w[0]);
          check("w_strb", w_strb, 4'hF);
          if (w_ready) begin
            $display("w     data=0x%08h last=%0b", w_data, w_last);
            void'(exp_w.pop_front());
          end
        end
      end
    end
  end

  // Automatic B responder: b_valid for one cycle, two cycles after the last beat.
  initial begin
    b_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && auto_b && w_valid && w_ready && w_last) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_auto = 1'b1;
        @(posedge clk); #1;
        b_auto = 1'b0;
      end
    end
  end

  // Alternating w_ready source for the stall test.
  initial begin
    w_tog = 1'b1;
    forever begin
      @(posedge clk); #1;
      w_tog = ~w_tog;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one victim on the inputs; accepted victims get their full expected response queued.
  task automatic drive_victim(input logic [26:0] a, input logic [31:0] base,
                              input logic [1:0] mi, input bit accept);
    en = 1'b1;
    addr = a;
    missIdx = mi;
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = base + 32'(i);
    if (accept) begin
      exp_wend.push_back(mi);
      exp_aw.push_back({a, 5'b0});
      for (int i = 0; i < 8; i++) exp_w.push_back({(i == 7), base + 32'(i)});
    end
  endtask

  task automatic enq(input logic [26:0] a, input logic [31:0] base, input logic [1:0] mi);
    drive_victim(a, base, mi, 1'b1);
    tick();
    en = 1'b0;
  endtask

  // Wait (bounded) until at most `target` beats remain expected; returns 2 units after a negedge.
  task automatic wait_w(input int target);
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (exp_w.size() > target && n < 2000);
    if (exp_w.size() > target) fail_now("wait_w_timeout", $sformatf("%0d beats still pending, expected <= %0d", exp_w.size(), target));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while ((exp_w.size() + exp_aw.size() + exp_wend.size()) != 0 && n < 3000);
    if ((exp_w.size() + exp_aw.size() + exp_wend.size()) != 0) fail_now("drain_timeout", "expected queues not drained");
    repeat (6) tick();
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b0; addr = '0; data = '0; missIdx = '0; chk_addr = '0;
    aw_ready = 1'b0; w_rdy_man = 1'b0; w_toggle = 1'b0; auto_b = 1'b0; b_man = 1'b0;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_full", full, 1'b0);
    check("rst_wend", wend, 1'b0);
    check("rst_missidx_o", missIdx_o, 2'd0);
    check("rst_aw_valid", aw_valid, 1'b0);
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_w_last", w_last, 1'b0);
    check("rst_conflict", chk_conflict, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Single victim, full-speed handshakes
    aw_ready = 1'b1; w_rdy_man = 1'b1; auto_b = 1'b1; chk_addr = 27'h100;
    drive_victim(27'h100, 32'hA0, 2'd2, 1'b1);
    #1 check("t1_bypass_conflict", chk_conflict, 1'b1);
    tick();
    en = 1'b0;
    check("t1_wend_latency", wend, 1'b1);
    wait_w(4);
    check("t1_conflict_burst", chk_conflict, 1'b1);
    wait_idle();
    check("t1_conflict_drained", chk_conflict, 1'b0);
    check("t1_full_drained", full, 1'b0);

    // Fill the queue with AW stalled; a fifth victim must be refused
    aw_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_victim(27'h10 + 27'(k), 32'h1000 + 32'(k * 16), 2'(k), 1'b1);
      tick();
    end
    en = 1'b0;
    @(negedge clk);
    check("t2_full", full, 1'b1);
    tick();
    drive_victim(27'h77, 32'h5000, 2'd3, 1'b0);
    tick();
    en = 1'b0;
    check("t2_no_wend", wend, 1'b0);
    check("t2_still_full", full, 1'b1);
    aw_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_valid && n < 500);
    if (!b_valid) fail_now("t2_b_timeout", "no B response seen");
    check("t2_full_at_b", full, 1'b1);
    @(negedge clk);
    check("t2_full_drop", full, 1'b0);
    wait_idle();

    // w_ready alternating: beats must hold while stalled
    w_toggle = 1'b1;
    enq(27'h300, 32'hC0, 2'd1);
    wait_idle();
    w_toggle = 1'b0;

    // Conflict window closes the cycle after B; same-cycle bypass
    auto_b = 1'b0; chk_addr = 27'h100;
    enq(27'h100, 32'hD0, 2'd0);
    wait_w(0);
    tick();
    @(negedge clk);
    check("t4_conflict_in_b", chk_conflict, 1'b1);
    tick();
    b_man = 1'b1;
    tick();
    b_man = 1'b0;
    @(negedge clk);
    check("t4_conflict_after_b", chk_conflict, 1'b0);
    tick();
    chk_addr = 27'h200;
    drive_victim(27'h200, 32'hE0, 2'd3, 1'b1);
    #1 check("t4_bypass", chk_conflict, 1'b1);
    chk_addr = 27'h201;
    #1 check("t4_no_conflict", chk_conflict, 1'b0);
    chk_addr = 27'h200;
    tick();
    en = 1'b0;
    auto_b = 1'b1;
    wait_idle();

    // Enqueue colliding with B: refused at count 4, accepted at count 3
    auto_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_victim(27'h40 + 27'(k), 32'h2000 + 32'(k * 16), 2'(k), 1'b1);
      tick();
    end
    en = 1'b0;
    wait_w(24);
    tick();
    b_man = 1'b1;
    drive_victim(27'h99, 32'h9000, 2'd1, 1'b0);
    #1 check("t5_full_blocks", full, 1'b1);
    tick();
    b_man = 1'b0; en = 1'b0;
    check("t5_rejected_no_wend", wend, 1'b0);
    check("t5_full_after_b", full, 1'b0);
    wait_w(16);
    tick();
    b_man = 1'b1;
    drive_victim(27'h55, 32'h6000, 2'd2, 1'b1);
    tick();
    b_man = 1'b0; en = 1'b0;
    check("t5_accepted_wend", wend, 1'b1);
    check("t5_count_held", full, 1'b0);
    enq(27'h56, 32'h7000, 2'd3);
    check("t5_full_count4", full, 1'b1);
    auto_b = 1'b1;
    wait_idle();

    // Reset in the middle of a burst, then a clean transfer
    chk_addr = 27'h123;
    enq(27'h123, 32'hF0, 2'd1);
    wait_w(4);
    rst = 1'b0;
    exp_w.delete(); exp_aw.delete(); exp_wend.delete();
    tick();
    check("t6_full", full, 1'b0);
    check("t6_wend", wend, 1'b0);
    check("t6_missidx_o", missIdx_o, 2'd0);
    check("t6_aw_valid", aw_valid, 1'b0);
    check("t6_w_valid", w_valid, 1'b0);
    check("t6_w_last", w_last, 1'b0);
    check("t6_conflict", chk_conflict, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    enq(27'h321, 32'h30, 2'd3);
    check("t6_wend_after_reset", wend, 1'b1);
    wait_idle();
    check("t6_full_idle", full, 1'b0);

    check("end_queues_empty", 64'(exp_wend.size() + exp_aw.size() + exp_w.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
